// File: rtl/rv_fp_decode.sv
// rv_fp_decode
//   Pipelined decode stage for the RISC-V F (and, with FLEN=64, D) extension.
//   A raw 32-bit instruction accepted on the input stream is decoded combinationally.
//   The result is registered into a primary output register backed by one skid
//   register. o_in_ready is driven only from the skid-valid flop.
//
// Parameters
//   FLEN           32 = F only, 64 = F+D; any other value stops elaboration
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_in_valid / o_in_ready / i_in_inst / i_in_pc / i_frm   input beat, fcsr.frm
//   o_out_valid / i_out_ready                               output handshake
//   o_out_op, o_out_fmt, o_out_rm                           op code, format, rounding mode
//   o_out_rd, o_out_rs1, o_out_rs2, o_out_rs3               raw register specifiers
//   o_out_imm                                               load/store offset
//   o_out_rs1_int, o_out_rd_int                             integer RF routing
//   o_out_illegal, o_out_pc                                 illegal flag, carried PC
//
// Build option
//   RV_FP_DECODE_DYN_RM_EN   resolve DYN rounding against i_frm and flag
//                            reserved rounding modes as illegal
module rv_fp_decode #(
    parameter int FLEN = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_inst,
    input  logic [31:0] i_in_pc,
    input  logic [2:0]  i_frm,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [4:0]  o_out_op,
    output logic        o_out_fmt,
    output logic [2:0]  o_out_rm,
    output logic [4:0]  o_out_rd,
    output logic [4:0]  o_out_rs1,
    output logic [4:0]  o_out_rs2,
    output logic [4:0]  o_out_rs3,
    output logic [11:0] o_out_imm,
    output logic        o_out_rs1_int,
    output logic        o_out_rd_int,
    output logic        o_out_illegal,
    output logic [31:0] o_out_pc
);
    localparam bit D_EN = (FLEN == 64);

    generate
        if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
            $error("rv_fp_decode: FLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;
    localparam logic [6:0] OPC_MADD  = 7'b1000011;
    localparam logic [6:0] OPC_MSUB  = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB = 7'b1001011;
    localparam logic [6:0] OPC_NMADD = 7'b1001111;
    localparam logic [6:0] OPC_OPFP  = 7'b1010011;

    typedef enum logic [4:0] {
        OP_FLOAD   = 5'd0,  OP_FSTORE  = 5'd1,  OP_FMADD   = 5'd2,  OP_FMSUB   = 5'd3,
        OP_FNMSUB  = 5'd4,  OP_FNMADD  = 5'd5,  OP_FADD    = 5'd6,  OP_FSUB    = 5'd7,
        OP_FMUL    = 5'd8,  OP_FDIV    = 5'd9,  OP_FSQRT   = 5'd10, OP_FSGNJ   = 5'd11,
        OP_FSGNJN  = 5'd12, OP_FSGNJX  = 5'd13, OP_FMIN    = 5'd14, OP_FMAX    = 5'd15,
        OP_FCVT_W  = 5'd16, OP_FCVT_WU = 5'd17, OP_FCVT_FW = 5'd18, OP_FCVT_FWU = 5'd19,
        OP_FCVT_FF = 5'd20, OP_FMV_X   = 5'd21, OP_FCLASS  = 5'd22, OP_FMV_F   = 5'd23,
        OP_FEQ     = 5'd24, OP_FLT     = 5'd25, OP_FLE     = 5'd26, OP_ILLEGAL = 5'd31
    } op_e;

    typedef struct packed {
        op_e         op;
        logic        fmt;
        logic [2:0]  rm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [11:0] imm;
        logic        rs1_int;
        logic        rd_int;
        logic        illegal;
        logic [31:0] pc;
    } uop_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_f5;
    logic [1:0]  w_fmt2;
    logic [4:0]  w_rs2;
    logic        w_fmt_ok;
    op_e         w_op;
    logic        w_fmt;
    logic        w_has_rm;
    logic        w_rs1_int;
    logic        w_rd_int;
    logic [11:0] w_imm;
    logic [2:0]  w_rm;
    logic        w_rm_bad;
    logic        w_illegal;
    uop_t        w_beat;

    assign w_opc    = i_in_inst[6:0];
    assign w_f3     = i_in_inst[14:12];
    assign w_f5     = i_in_inst[31:27];
    assign w_fmt2   = i_in_inst[26:25];
    assign w_rs2    = i_in_inst[24:20];
    assign w_fmt_ok = (w_fmt2 == 2'b00) || ((w_fmt2 == 2'b01) && D_EN);

    always_comb begin
        w_op      = OP_ILLEGAL;
        w_fmt     = 1'b0;
        w_has_rm  = 1'b0;
        w_rs1_int = 1'b0;
        w_rd_int  = 1'b0;
        w_imm     = '0;
        case (w_opc)
            OPC_LOAD, OPC_STORE: begin
                if (w_f3 == 3'b010 || (w_f3 == 3'b011 && D_EN)) begin
                    w_op      = (w_opc == OPC_LOAD) ? OP_FLOAD : OP_FSTORE;
                    w_fmt     = w_f3[0];
                    w_rs1_int = 1'b1;
                    w_imm     = (w_opc == OPC_LOAD) ? i_in_inst[31:20]
                                                    : {i_in_inst[31:25], i_in_inst[11:7]};
                end
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                if (w_fmt_ok) begin
                    w_fmt    = w_fmt2[0];
                    w_has_rm = 1'b1;
                    case (w_opc)
                        OPC_MADD:  w_op = OP_FMADD;
                        OPC_MSUB:  w_op = OP_FMSUB;
                        OPC_NMSUB: w_op = OP_FNMSUB;
                        default:   w_op = OP_FNMADD;
                    endcase
                end
            end
            OPC_OPFP: begin
                if (w_fmt_ok) begin
                    w_fmt = w_fmt2[0];
                    case (w_f5)
                        5'b00000: begin w_op = OP_FADD; w_has_rm = 1'b1; end
                        5'b00001: begin w_op = OP_FSUB; w_has_rm = 1'b1; end
                        5'b00010: begin w_op = OP_FMUL; w_has_rm = 1'b1; end
                        5'b00011: begin w_op = OP_FDIV; w_has_rm = 1'b1; end
                        5'b01011: if (w_rs2 == 5'd0) begin w_op = OP_FSQRT; w_has_rm = 1'b1; end
                        5'b00100: case (w_f3)
                            3'b000:  w_op = OP_FSGNJ;
                            3'b001:  w_op = OP_FSGNJN;
                            3'b010:  w_op = OP_FSGNJX;
                            default: w_op = OP_ILLEGAL;
                        endcase
                        5'b00101: case (w_f3)
                            3'b000:  w_op = OP_FMIN;
                            3'b001:  w_op = OP_FMAX;
                            default: w_op = OP_ILLEGAL;
                        endcase
                        5'b11000: if (w_rs2[4:1] == 4'd0) begin
                            w_op     = w_rs2[0] ? OP_FCVT_WU : OP_FCVT_W;
                            w_rd_int = 1'b1;
                            w_has_rm = 1'b1;
                        end
                        5'b11010: if (w_rs2[4:1] == 4'd0) begin
                            w_op      = w_rs2[0] ? OP_FCVT_FWU : OP_FCVT_FW;
                            w_rs1_int = 1'b1;
                            w_has_rm  = 1'b1;
                        end
                        // rs2 names the source format, which must be the other one
                        5'b01000: if (D_EN && ((w_fmt2 == 2'b00 && w_rs2 == 5'd1) ||
                                               (w_fmt2 == 2'b01 && w_rs2 == 5'd0))) begin
                            w_op     = OP_FCVT_FF;
                            w_has_rm = 1'b1;
                        end
                        5'b11100: begin
                            if (w_f3 == 3'b000 && w_fmt2 == 2'b00) begin
                                w_op = OP_FMV_X;  w_rd_int = 1'b1;
                            end else if (w_f3 == 3'b001) begin
                                w_op = OP_FCLASS; w_rd_int = 1'b1;
                            end
                        end
                        5'b10100: begin
                            w_rd_int = 1'b1;
                            case (w_f3)
                                3'b000:  w_op = OP_FLE;
                                3'b001:  w_op = OP_FLT;
                                3'b010:  w_op = OP_FEQ;
                                default: w_op = OP_ILLEGAL;
                            endcase
                        end
                        5'b11110: if (w_f3 == 3'b000 && w_fmt2 == 2'b00) begin
                            w_op = OP_FMV_F; w_rs1_int = 1'b1;
                        end
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
            end
            default: w_op = OP_ILLEGAL;
        endcase
    end

`ifdef RV_FP_DECODE_DYN_RM_EN
    logic [2:0] w_rm_res;
    assign w_rm_res = (w_f3 == 3'b111) ? i_frm : w_f3;
    assign w_rm     = w_has_rm ? w_rm_res : 3'b000;
    // Covers the reserved 101/110 encodings and a reserved/DYN value in frm.
    assign w_rm_bad = w_has_rm && (w_rm_res >= 3'd5);
`else
    logic w_unused_rm;
    assign w_unused_rm = ^{i_frm, w_has_rm};
    assign w_rm        = w_f3;
    assign w_rm_bad    = 1'b0;
`endif

    assign w_illegal = (w_op == OP_ILLEGAL) || w_rm_bad;

    always_comb begin
        w_beat         = '0;
        w_beat.op      = w_illegal ? OP_ILLEGAL : w_op;
        w_beat.fmt     = w_illegal ? 1'b0 : w_fmt;
        w_beat.rm      = w_rm;
        w_beat.rd      = i_in_inst[11:7];
        w_beat.rs1     = i_in_inst[19:15];
        w_beat.rs2     = i_in_inst[24:20];
        w_beat.rs3     = i_in_inst[31:27];
        w_beat.imm     = w_illegal ? 12'd0 : w_imm;
        w_beat.rs1_int = !w_illegal && w_rs1_int;
        w_beat.rd_int  = !w_illegal && w_rd_int;
        w_beat.illegal = w_illegal;
        w_beat.pc      = i_in_pc;
    end

    uop_t r_out;
    uop_t r_skid;
    logic r_out_valid;
    logic r_skid_valid;
    logic w_acc_in;
    logic w_out_free;

    assign o_in_ready = !r_skid_valid;
    assign w_acc_in   = i_in_valid && !r_skid_valid;
    assign w_out_free = !r_out_valid || i_out_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Older skid beat goes out first; any new beat backfills the skid.
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_acc_in;
                if (w_acc_in) r_skid <= w_beat;
            end else begin
                r_out_valid <= w_acc_in;
                if (w_acc_in) r_out <= w_beat;
            end
        end else if (w_acc_in) begin
            r_skid       <= w_beat;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_op      = r_out.op;
    assign o_out_fmt     = r_out.fmt;
    assign o_out_rm      = r_out.rm;
    assign o_out_rd      = r_out.rd;
    assign o_out_rs1     = r_out.rs1;
    assign o_out_rs2     = r_out.rs2;
    assign o_out_rs3     = r_out.rs3;
    assign o_out_imm     = r_out.imm;
    assign o_out_rs1_int = r_out.rs1_int;
    assign o_out_rd_int  = r_out.rd_int;
    assign o_out_illegal = r_out.illegal;
    assign o_out_pc      = r_out.pc;
endmodule

// File: tb/tb_rv_fp_decode.sv
// Testbench for rv_fp_decode: an FLEN=32 and an FLEN=64 instance share one input stream.
module tb_rv_fp_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [2:0]  frm = '0;
    logic        out_ready = 1'b0;

    logic        s_in_ready, s_out_valid, s_fmt, s_rs1_int, s_rd_int, s_ill;
    logic [4:0]  s_op, s_rd, s_rs1, s_rs2, s_rs3;
    logic [2:0]  s_rm;
    logic [11:0] s_imm;
    logic [31:0] s_pc;
    logic        d_in_ready, d_out_valid, d_fmt, d_rs1_int, d_rd_int, d_ill;
    logic [4:0]  d_op, d_rd, d_rs1, d_rs2, d_rs3;
    logic [2:0]  d_rm;
    logic [11:0] d_imm;
    logic [31:0] d_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv_fp_decode #(.FLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
        .i_in_inst(in_inst), .i_in_pc(in_pc), .i_frm(frm),
        .o_out_valid(s_out_valid), .i_out_ready(out_ready),
        .o_out_op(s_op), .o_out_fmt(s_fmt), .o_out_rm(s_rm),
        .o_out_rd(s_rd), .o_out_rs1(s_rs1), .o_out_rs2(s_rs2), .o_out_rs3(s_rs3),
        .o_out_imm(s_imm), .o_out_rs1_int(s_rs1_int), .o_out_rd_int(s_rd_int),
        .o_out_illegal(s_ill), .o_out_pc(s_pc)
    );

    rv_fp_decode #(.FLEN(64)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(d_in_ready),
        .i_in_inst(in_inst), .i_in_pc(in_pc), .i_frm(frm),
        .o_out_valid(d_out_valid), .i_out_ready(out_ready),
        .o_out_op(d_op), .o_out_fmt(d_fmt), .o_out_rm(d_rm),
        .o_out_rd(d_rd), .o_out_rs1(d_rs1), .o_out_rs2(d_rs2), .o_out_rs3(d_rs3),
        .o_out_imm(d_imm), .o_out_rs1_int(d_rs1_int), .o_out_rd_int(d_rd_int),
        .o_out_illegal(d_ill), .o_out_pc(d_pc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  op32;
        logic [4:0]  op64;
        logic        fmt;
        logic        rs1i;
        logic        rdi;
        logic [11:0] imm;
    } vec_t;

    // Hand-decoded words; op 31 marks ILLEGAL for that FLEN.
    vec_t tbl [23] = '{
        '{32'h0020F0D3, 5'd6,  5'd6,  1'b0, 1'b0, 1'b0, 12'h000}, // fadd.s rm=DYN
        '{32'h02208053, 5'd31, 5'd6,  1'b1, 1'b0, 1'b0, 12'h000}, // fadd.d
        '{32'hA0208553, 5'd26, 5'd26, 1'b0, 1'b0, 1'b1, 12'h000}, // funct3 000 -> fle.s x10
        '{32'hA020A553, 5'd24, 5'd24, 1'b0, 1'b0, 1'b1, 12'h000}, // feq.s x10
        '{32'h00052087, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 12'h000}, // flw f1,0(x10)
        '{32'h00053087, 5'd31, 5'd0,  1'b1, 1'b1, 1'b0, 12'h000}, // fld f1,0(x10)
        '{32'hFE22AE27, 5'd1,  5'd1,  1'b0, 1'b1, 1'b0, 12'hFFC}, // fsw f2,-4(x5)
        '{32'h203100C3, 5'd2,  5'd2,  1'b0, 1'b0, 1'b0, 12'h000}, // fmadd.s
        '{32'h223100C3, 5'd31, 5'd2,  1'b1, 1'b0, 1'b0, 12'h000}, // fmadd.d
        '{32'hE00182D3, 5'd21, 5'd21, 1'b0, 1'b0, 1'b1, 12'h000}, // fmv.x.w
        '{32'hE20182D3, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 12'h000}, // fmv.x with fmt D
        '{32'hE00190D3, 5'd22, 5'd22, 1'b0, 1'b0, 1'b1, 12'h000}, // fclass.s
        '{32'h401100D3, 5'd31, 5'd20, 1'b0, 1'b0, 1'b0, 12'h000}, // fcvt.s.d
        '{32'h58100053, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 12'h000}, // fsqrt rs2!=0
        '{32'h58000053, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0, 12'h000}, // fsqrt.s
        '{32'h00000013, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 12'h000}, // integer opcode
        '{32'hC00110D3, 5'd16, 5'd16, 1'b0, 1'b0, 1'b1, 12'h000}, // fcvt.w.s
        '{32'hF00100D3, 5'd23, 5'd23, 1'b0, 1'b1, 1'b0, 12'h000}, // fmv.w.x
        '{32'h203120D3, 5'd13, 5'd13, 1'b0, 1'b0, 1'b0, 12'h000}, // fsgnjx.s
        '{32'h203130D3, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 12'h000}, // sgnj funct3 011
        '{32'hD00100D3, 5'd18, 5'd18, 1'b0, 1'b1, 1'b0, 12'h000}, // fcvt.s.w
        '{32'h0420F0D3, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 12'h000}, // fmt 10
        '{32'h28311053, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 12'h000}  // fmax.s
    };

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  frm;
        logic [4:0]  op;
        logic [2:0]  rm;
        logic        chk_rm;
    } rmv_t;

`ifdef RV_FP_DECODE_DYN_RM_EN
    rmv_t rmt [7] = '{
        '{32'h0020F0D3, 3'd1, 5'd6,  3'd1, 1'b1},
        '{32'h0020D0D3, 3'd0, 5'd31, 3'd0, 1'b0},
        '{32'h0020F0D3, 3'd6, 5'd31, 3'd0, 1'b0},
        '{32'h0020F0D3, 3'd7, 5'd31, 3'd0, 1'b0},
        '{32'h00052087, 3'd3, 5'd0,  3'd0, 1'b1},
        '{32'h203100C3, 3'd4, 5'd2,  3'd0, 1'b1},
        '{32'h0020C0D3, 3'd2, 5'd6,  3'd4, 1'b1}
    };
`else
    rmv_t rmt [7] = '{
        '{32'h0020F0D3, 3'd1, 5'd6, 3'd7, 1'b1},
        '{32'h0020D0D3, 3'd0, 5'd6, 3'd5, 1'b1},
        '{32'h0020F0D3, 3'd6, 5'd6, 3'd7, 1'b1},
        '{32'h0020F0D3, 3'd7, 5'd6, 3'd7, 1'b1},
        '{32'h00052087, 3'd3, 5'd0, 3'd2, 1'b1},
        '{32'h203100C3, 3'd4, 5'd2, 3'd0, 1'b1},
        '{32'h0020C0D3, 3'd2, 5'd6, 3'd4, 1'b1}
    };
`endif

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", s_out_valid); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", s_in_ready); end
        checks++; if ({s_op, s_pc, s_ill, s_imm} !== '0) begin errors++; $display("FAIL reset_data: got op=%0d pc=%h ill=%0b imm=%h want 0", s_op, s_pc, s_ill, s_imm); end
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid64: got %0b want 0", d_out_valid); end
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic        e_ill32, e_ill64;
        logic [19:0] e_regs;
        logic [13:0] e_side;
        out_ready = 1'b1;
        frm = 3'd0;
        for (int i = 0; i < 23; i++) begin
            in_valid = 1'b1;
            in_inst  = tbl[i].inst;
            in_pc    = 32'h1000 + 32'(i) * 4;
            e_ill32  = (tbl[i].op32 == 5'd31);
            e_ill64  = (tbl[i].op64 == 5'd31);
            e_regs   = {in_inst[11:7], in_inst[19:15], in_inst[24:20], in_inst[31:27]};
            @(posedge clk); #1;
            checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL dec_valid32[%0d]: got %0b want 1", i, s_out_valid); end
            checks++; if (s_op !== tbl[i].op32) begin errors++; $display("FAIL dec_op32[%0d]: got %0d want %0d", i, s_op, tbl[i].op32); end
            checks++; if (s_ill !== e_ill32) begin errors++; $display("FAIL dec_ill32[%0d]: got %0b want %0b", i, s_ill, e_ill32); end
            checks++; if ({s_rd, s_rs1, s_rs2, s_rs3} !== e_regs) begin errors++; $display("FAIL dec_regs32[%0d]: got %h want %h", i, {s_rd, s_rs1, s_rs2, s_rs3}, e_regs); end
            checks++; if (s_pc !== 32'h1000 + 32'(i) * 4) begin errors++; $display("FAIL dec_pc32[%0d]: got %h", i, s_pc); end
            e_side = e_ill32 ? 14'd0 : {tbl[i].rs1i, tbl[i].rdi, tbl[i].imm};
            checks++; if ({s_rs1_int, s_rd_int, s_imm} !== e_side) begin errors++; $display("FAIL dec_side32[%0d]: got %h want %h", i, {s_rs1_int, s_rd_int, s_imm}, e_side); end
            if (!e_ill32) begin
                checks++; if (s_fmt !== tbl[i].fmt) begin errors++; $display("FAIL dec_fmt32[%0d]: got %0b want %0b", i, s_fmt, tbl[i].fmt); end
            end
            checks++; if (d_op !== tbl[i].op64) begin errors++; $display("FAIL dec_op64[%0d]: got %0d want %0d", i, d_op, tbl[i].op64); end
            checks++; if (d_ill !== e_ill64) begin errors++; $display("FAIL dec_ill64[%0d]: got %0b want %0b", i, d_ill, e_ill64); end
            checks++; if ({d_rd, d_rs1, d_rs2, d_rs3} !== e_regs) begin errors++; $display("FAIL dec_regs64[%0d]: got %h want %h", i, {d_rd, d_rs1, d_rs2, d_rs3}, e_regs); end
            e_side = e_ill64 ? 14'd0 : {tbl[i].rs1i, tbl[i].rdi, tbl[i].imm};
            checks++; if ({d_rs1_int, d_rd_int, d_imm} !== e_side) begin errors++; $display("FAIL dec_side64[%0d]: got %h want %h", i, {d_rs1_int, d_rd_int, d_imm}, e_side); end
            if (!e_ill64) begin
                checks++; if (d_fmt !== tbl[i].fmt) begin errors++; $display("FAIL dec_fmt64[%0d]: got %0b want %0b", i, d_fmt, tbl[i].fmt); end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rm();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_inst  = rmt[i].inst;
            frm      = rmt[i].frm;
            in_pc    = 32'h2000 + 32'(i);
            @(posedge clk); #1;
            frm = 3'd0;
            checks++; if (s_op !== rmt[i].op) begin errors++; $display("FAIL rm_op[%0d]: got %0d want %0d", i, s_op, rmt[i].op); end
            checks++; if (s_ill !== (rmt[i].op == 5'd31)) begin errors++; $display("FAIL rm_ill[%0d]: got %0b", i, s_ill); end
            if (rmt[i].chk_rm) begin
                checks++; if (s_rm !== rmt[i].rm) begin errors++; $display("FAIL rm_val[%0d]: got %0d want %0d", i, s_rm, rmt[i].rm); end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_stall();
        out_ready = 1'b0;
        in_inst   = 32'h0020F0D3;
        in_valid  = 1'b1; in_pc = 32'hA0;
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready0: got %0b want 1", s_in_ready); end
        @(posedge clk); #1;
        in_pc = 32'hB0;
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1: got %0b want 1", s_in_ready); end
        checks++; if (s_pc !== 32'hA0 || s_out_valid !== 1'b1) begin errors++; $display("FAIL stall_out1: got v=%0b pc=%h want v=1 pc=a0", s_out_valid, s_pc); end
        @(posedge clk); #1;
        in_pc = 32'hC0;
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready2: got %0b want 0", s_in_ready); end
        checks++; if (s_pc !== 32'hA0) begin errors++; $display("FAIL stall_hold2: got %h want a0", s_pc); end
        @(posedge clk); #1;
        checks++; if (s_in_ready !== 1'b0 || s_pc !== 32'hA0) begin errors++; $display("FAIL stall_hold3: got rdy=%0b pc=%h want rdy=0 pc=a0", s_in_ready, s_pc); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_out_valid !== 1'b1 || s_pc !== 32'hB0) begin errors++; $display("FAIL drain_b: got v=%0b pc=%h want v=1 pc=b0", s_out_valid, s_pc); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %0b want 1", s_in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_pc !== 32'hC0) begin errors++; $display("FAIL drain_c: got v=%0b pc=%h want v=1 pc=c0", s_out_valid, s_pc); end
        @(posedge clk); #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b want 0", s_out_valid); end
    endtask

    task automatic test_random_flow();
        logic [63:0] sb[$];
        logic [63:0] e;
        logic [31:0] next_pc = 32'h10000;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_pc = '0;
        while (recv < 1000 && cyc < 20000) begin
            if (prev_stall) begin
                checks++; if (s_out_valid !== 1'b1 || s_pc !== prev_pc) begin errors++; $display("FAIL rnd_hold: got v=%0b pc=%h want v=1 pc=%h", s_out_valid, s_pc, prev_pc); end
            end
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = next_pc;
            in_inst   = $urandom;
            if (in_valid && s_in_ready) begin
                sb.push_back({in_pc, in_inst});
                sent++;
                next_pc += 4;
            end
            if (s_out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rnd_extra: got pc=%h want no beat", s_pc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({s_pc, s_rd, s_rs1, s_rs2, s_rs3} !== {e[63:32], e[11:7], e[19:15], e[24:20], e[31:27]}) begin
                        errors++;
                        $display("FAIL rnd_order: got pc=%h regs=%h want pc=%h regs=%h", s_pc,
                                 {s_rd, s_rs1, s_rs2, s_rs3}, e[63:32], {e[11:7], e[19:15], e[24:20], e[31:27]});
                    end
                end
                recv++;
            end
            prev_stall = s_out_valid && !out_ready;
            prev_pc    = s_pc;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (recv !== 1000 || sb.size() !== 0) begin errors++; $display("FAIL rnd_count: got recv=%0d left=%0d want 1000/0", recv, sb.size()); end
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_inst   = 32'h58000053;
        in_valid  = 1'b1; in_pc = 32'hD0;
        @(posedge clk); #1;
        in_pc = 32'hD4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin errors++; $display("FAIL rst_fill: got rdy=%0b v=%0b want 0/1", s_in_ready, s_out_valid); end
        #3 rst = 1'b1;
        #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b want 0", s_out_valid); end
        checks++; if (s_in_ready !== 1'b1 || s_pc !== 32'h0 || s_op !== 5'd0) begin errors++; $display("FAIL rst_async_state: got rdy=%0b pc=%h op=%0d want 1/0/0", s_in_ready, s_pc, s_op); end
        @(posedge clk); #3 rst = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0020F0D3; in_pc = 32'hE0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_pc !== 32'hE0 || s_op !== 5'd6) begin errors++; $display("FAIL rst_next_beat: got v=%0b pc=%h op=%0d want 1/e0/6", s_out_valid, s_pc, s_op); end
        @(posedge clk); #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale: got %0b want 0", s_out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_rm();
        test_back_to_back_stall();
        test_random_flow();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
